// File: rtl/bitnet_pkg.sv
// Shared types and helpers for the majority-gate layer datapath.
// Holds the trainer FSM encoding, the 3-input majority and index-width sizing.
package bitnet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Width of a neuron index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maj_lane.sv
// Per-neuron backward/learning lane: majority of the downstream bits, mismatch
// against the forward bit, and the saturating counter / control-flip update.
module maj_lane
    import bitnet_pkg::*;
#(
    parameter int CNT_W       = 2,
    parameter int FLIP_THRESH = 3
) (
    input  logic             b1_i,
    input  logic             b2_i,
    input  logic             b3_i,
    input  logic             fwd_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             ctrl_i,
    input  logic             learn_i,
    output logic             t_o,
    output logic             m_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ctrl_o,
    output logic             flip_o
);

    localparam logic [CNT_W:0] THRESH = (CNT_W + 1)'(FLIP_THRESH);

    logic [CNT_W:0] cnt_inc;

    always_comb begin
        t_o     = maj3(b1_i, b2_i, b3_i);
        m_o     = t_o ^ fwd_i;
        cnt_inc = {1'b0, cnt_i} + (CNT_W + 1)'(1);
        cnt_o   = cnt_i;
        ctrl_o  = ctrl_i;
        flip_o  = 1'b0;
        if (learn_i) begin
            if (m_o) begin
                // Reaching the threshold flips the control bit and restarts the count.
                if (cnt_inc >= THRESH) begin
                    ctrl_o = ~ctrl_i;
                    cnt_o  = '0;
                    flip_o = 1'b1;
                end else begin
                    cnt_o = cnt_inc[CNT_W-1:0];
                end
            end else if (cnt_i != '0) begin
                cnt_o = cnt_i - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/maj_layer_trainer.sv
// Backward pass and control-bit learner for one majority-gate layer.
// Scans one neuron per cycle, then holds the result until upstream accepts it.
module maj_layer_trainer
    import bitnet_pkg::*;
#(
    parameter int   N_NEURONS   = 8,
    parameter int   CNT_W       = 2,
    parameter int   FLIP_THRESH = 3,
    parameter logic CTRL_INIT   = 1'b0
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             learn_en,
    input  logic [N_NEURONS-1:0]             fwd_out,
    input  logic [N_NEURONS-1:0]             bwd_in1,
    input  logic [N_NEURONS-1:0]             bwd_in2,
    input  logic [N_NEURONS-1:0]             bwd_in3,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_NEURONS-1:0]             bwd_out,
    output logic                             bcontrol,
    output logic [$clog2(N_NEURONS+1)-1:0]   flips,
    output logic [N_NEURONS-1:0]             ctrl_out
);

    localparam int IDX_W = idx_width(N_NEURONS);
    localparam int FL_W  = $clog2(N_NEURONS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [N_NEURONS-1:0]             ctrl_q, ctrl_d;
    logic [N_NEURONS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_NEURONS-1:0]             bwd_q, bwd_d;
    logic                             bcontrol_q, bcontrol_d;
    logic [FL_W-1:0]                  flips_q, flips_d;

    logic [N_NEURONS-1:0]             fwd_q, b1_q, b2_q, b3_q;
    logic                             learn_q;
    logic                             capture;

    logic                             lane_t, lane_m, lane_ctrl, lane_flip;
    logic [CNT_W-1:0]                 lane_cnt;

    maj_lane #(
        .CNT_W       (CNT_W),
        .FLIP_THRESH (FLIP_THRESH)
    ) u_lane (
        .b1_i    (b1_q[idx_q]),
        .b2_i    (b2_q[idx_q]),
        .b3_i    (b3_q[idx_q]),
        .fwd_i   (fwd_q[idx_q]),
        .cnt_i   (cnt_q[idx_q]),
        .ctrl_i  (ctrl_q[idx_q]),
        .learn_i (learn_q),
        .t_o     (lane_t),
        .m_o     (lane_m),
        .cnt_o   (lane_cnt),
        .ctrl_o  (lane_ctrl),
        .flip_o  (lane_flip)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        bwd_d      = bwd_q;
        bcontrol_d = bcontrol_q;
        flips_d    = flips_q;
        capture    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Hold off upstream while reset is asserted.
                in_ready = rst_n_in;
                if (in_valid && rst_n_in) begin
                    capture    = 1'b1;
                    bcontrol_d = 1'b0;
                    flips_d    = '0;
                    idx_d      = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                bwd_d[idx_q]  = lane_t;
                bcontrol_d    = bcontrol_q | lane_m;
                ctrl_d[idx_q] = lane_ctrl;
                cnt_d[idx_q]  = lane_cnt;
                if (lane_flip) begin
                    flips_d = flips_q + FL_W'(1);
                end
                if (idx_q == LAST_IDX) begin
                    state_d = EMIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ctrl_q     <= {N_NEURONS{CTRL_INIT}};
            cnt_q      <= '0;
            bwd_q      <= '0;
            bcontrol_q <= 1'b0;
            flips_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ctrl_q     <= ctrl_d;
            cnt_q      <= cnt_d;
            bwd_q      <= bwd_d;
            bcontrol_q <= bcontrol_d;
            flips_q    <= flips_d;
        end
    end

    // Sample holding registers are only meaningful after a capture, so no reset.
    always_ff @(posedge clk_in) begin
        if (capture) begin
            fwd_q   <= fwd_out;
            b1_q    <= bwd_in1;
            b2_q    <= bwd_in2;
            b3_q    <= bwd_in3;
            learn_q <= learn_en;
        end
    end

    assign bwd_out  = bwd_q;
    assign bcontrol = bcontrol_q;
    assign flips    = flips_q;
    assign ctrl_out = ctrl_q;

endmodule

// File: doc/maj_layer_trainer.md
Name: maj_layer_trainer

Overview:
- Backward-direction counterpart to the forward majority-gate perceptron layer. Accepts one training sample per handshake: N forward output bits plus three downstream backward bits per neuron.
- Serially forms each neuron's backward bit as a plain 3-input majority. Emits the backward bit vector upstream together with a layer-level bcontrol error flag.
- Learns each neuron's forward control bit through a saturating mismatch counter.
- Sits between layer k's forward output register and layer k-1's backward input.

Parameters:
- N_NEURONS, 8, neurons in the layer (>=2).
- CNT_W, 2, width of each per-neuron mismatch counter.
- FLIP_THRESH, 3, counter value that triggers a control-bit flip (1..2^CNT_W-1).
- CTRL_INIT, 0, reset value replicated into every control bit.

Ports:
- clk_in, input, 1, single clock; all state on rising edge.
- rst_n_in, input, 1, asynchronous active-low reset.
- in_valid, input, 1, sample available.
- in_ready, output, 1, trainer can accept a sample.
- learn_en, input, 1, sampled with the input; 0 means compute backward bits only, no counter or control updates.
- fwd_out, input, N_NEURONS, forward output bit per neuron for this sample.
- bwd_in1, input, N_NEURONS, downstream backward bit 1 per neuron.
- bwd_in2, input, N_NEURONS, downstream backward bit 2 per neuron.
- bwd_in3, input, N_NEURONS, downstream backward bit 3 per neuron.
- out_valid, output, 1, backward result valid.
- out_ready, input, 1, upstream accepts result.
- bwd_out, output, N_NEURONS, backward bit per neuron, to layer k-1.
- bcontrol, output, 1, OR of all per-neuron mismatches for this sample.
- flips, output, $clog2(N_NEURONS+1), number of control bits flipped by this sample.
- ctrl_out, output, N_NEURONS, current learned control bits, to the forward layer.

Behaviour:
- Reset (async assert, sync-safe deassert by upstream): state IDLE; ctrl_out=CTRL_INIT per bit; all counters 0; bwd_out=0, bcontrol=0, flips=0; out_valid=0; in_ready=0 while rst_n_in low.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture fwd_out, bwd_in1..3 and learn_en; clear bcontrol and flips; idx=0; go to SCAN.
  - in_valid without a handshake has no effect.
- SCAN, one neuron per cycle, idx = 0..N_NEURONS-1:
  - Compute t = maj(bwd_in1[idx], bwd_in2[idx], bwd_in3[idx]) and m = t ^ fwd_out[idx].
  - Write bwd_out[idx] <= t and bcontrol <= bcontrol | m.
  - If learn_en was captured as 1:
    - m=1 and cnt+1 >= FLIP_THRESH: ctrl[idx] toggles, cnt <= 0, flips++.
    - m=1 otherwise: cnt++.
    - m=0: cnt decrements, saturating at 0.
  - If learn_en was captured as 0: counters and control bits are untouched.
  - idx == N_NEURONS-1: go to EMIT. Otherwise idx++.
  - in_ready=0 throughout SCAN.
- EMIT:
  - out_valid=1; bwd_out, bcontrol and flips are held stable.
  - On out_ready: out_valid falls next cycle and state returns to IDLE.
  - No new sample is accepted in the same cycle as the output handshake. Throughput is one sample per N_NEURONS+2 cycles minimum.
- Latency: if the input handshake occurs at edge T, out_valid is high after edge T+N_NEURONS.
- ctrl_out[idx] changes at the SCAN edge that processes idx and is otherwise stable. The forward layer must not sample ctrl_out mid-SCAN; it waits for out_valid.
- Counter boundary: cnt never exceeds FLIP_THRESH-1 and never wraps below 0.
- Backpressure: out_ready low holds EMIT indefinitely with outputs stable.
- Reset mid-SCAN or mid-EMIT aborts the sample. All learned state returns to reset values, and a partial sample is never emitted.

Decomposition:
- Shared package bitnet_pkg:
  - typedef for the FSM state enum (IDLE/SCAN/EMIT).
  - function maj3(a,b,c).
  - localparam IDX_W = $clog2(N_NEURONS) convention.
- One sub-module, maj_lane: purely combinational. Takes the selected neuron's three backward bits, fwd bit, cnt, ctrl and learn flag. Produces t, m, next cnt, next ctrl and a flip strobe. The top level handles only the FSM, index mux/demux and registers.

Test Plan:
- Reset check: N=4, FLIP_THRESH=2, CTRL_INIT=0. Hold rst_n_in low 3 cycles -> ctrl_out=0000, out_valid=0, in_ready=0. After release, in_ready=1.
- No-error sample: fwd_out=1010, bwd_in1=bwd_in2=1010, bwd_in3=0101, learn_en=1 -> out_valid exactly 4 edges after accept. Expect bwd_out=1010, bcontrol=0, flips=0, ctrl_out unchanged.
- Flip on threshold: the same sample with fwd_out=1011 (bit0 mismatched), applied twice with learn_en=1. First sample -> bcontrol=1, flips=0. Second -> flips=1, ctrl_out=0001.
- Decay and learn gating: a mismatch on bit2 followed by a match -> counter returns to 0; a third mismatch does not flip. Any mismatches with learn_en=0 -> bcontrol=1, ctrl_out and flips unchanged.
- Backpressure: hold out_ready=0 for 10 cycles in EMIT -> outputs stable, in_ready=0, in_valid ignored. Raising out_ready -> IDLE next cycle, and the next sample is accepted one cycle later.
- Reset mid-SCAN: pulse rst_n_in low at idx=2 -> ctrl_out=CTRL_INIT, no out_valid pulse, and the next sample processes normally.
